// File: rtl/ram_model_pkg.sv
// Shared types and helpers for the multiport RAM model: index math,
// read-window test and the saturating out-of-range counter add.
package ram_model_pkg;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
  } read_window_t;

  function automatic int unsigned log2_ceil(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic logic [63:0] word_index(input logic [63:0] byte_addr,
                                             input int unsigned data_w);
    return byte_addr >> log2_ceil(data_w / 8);
  endfunction

  // Single unsigned compare: an index below lo wraps to a huge offset.
  function automatic logic win_contains(input read_window_t win,
                                        input logic [63:0] idx);
    return (idx - win.lo) <= (win.hi - win.lo);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] acc,
                                            input logic [3:0] inc);
    logic [16:0] sum;
    sum = {1'b0, acc} + {13'd0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/multiport_ram_model_read_pipe.sv
// Per-port read data delay line; reset flushes every stage to zero.
import ram_model_pkg::*;

module ram_read_pipe #(
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              clock,
  input  logic              sync_reset,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage_reg [LATENCY];

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      for (int s = 0; s < LATENCY; s++) stage_reg[s] <= '0;
    end else begin
      stage_reg[0] <= din;
      for (int s = 1; s < LATENCY; s++) stage_reg[s] <= stage_reg[s-1];
    end
  end

  assign dout = stage_reg[LATENCY-1];

endmodule

// File: rtl/multiport_ram_model.sv
// N-port word-addressed bench memory with windowed, pipelined read-first
// reads, highest-port-wins write arbitration and out-of-range counting.
import ram_model_pkg::*;

module multiport_ram_model #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 1,
  parameter int READ_LO      = 0,
  parameter int READ_HI      = 100,
  parameter int INIT_LO      = 2560,
  parameter int INIT_HI      = 2660
) (
  input  logic                        clock,
  input  logic                        sync_reset,
  input  logic [NUM_PORTS*DATA_W-1:0] addr,
  input  logic [NUM_PORTS*DATA_W-1:0] data_in,
  input  logic [NUM_PORTS-1:0]        w_rq,
  output logic [NUM_PORTS*DATA_W-1:0] data_out,
  output logic                        wr_conflict,
  output logic [15:0]                 oob_count
);

  localparam int unsigned AW = log2_ceil(DEPTH);
  localparam logic [63:0] DEPTH_64 = 64'(DEPTH);
  localparam read_window_t READ_WINDOW = '{lo: 64'(READ_LO), hi: 64'(READ_HI)};
  localparam read_window_t INIT_WINDOW = '{lo: 64'(INIT_LO), hi: 64'(INIT_HI)};

  // Storage holds data XOR the preload pattern, so the all-zero power-up
  // image of the array reads back as the time-zero preload contents.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]        widx    [NUM_PORTS];
  logic [DATA_W-1:0]    raw_rd  [NUM_PORTS];
  logic [DATA_W-1:0]    wr_word [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_range;
  logic [NUM_PORTS-1:0] in_window;
  logic [NUM_PORTS-1:0] wr_en;

  logic        conflict_next;
  logic [3:0]  oob_hits;
  logic        wr_conflict_reg;
  logic [15:0] oob_count_reg;

  function automatic logic [DATA_W-1:0] preload_word(input logic [AW-1:0] w);
    logic [63:0] w64;
    w64 = 64'(w);
    return win_contains(INIT_WINDOW, w64) ? DATA_W'(w64) : '0;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      logic [63:0] idx;
      assign idx           = word_index(64'(addr[gi*DATA_W +: DATA_W]), DATA_W);
      assign in_range[gi]  = idx < DEPTH_64;
      assign in_window[gi] = in_range[gi] && win_contains(READ_WINDOW, idx);
      assign widx[gi]      = idx[AW-1:0];
      assign wr_en[gi]     = w_rq[gi] && in_range[gi] && !sync_reset;
      assign raw_rd[gi]    = in_window[gi] ? (mem[widx[gi]] ^ preload_word(widx[gi])) : '0;
      assign wr_word[gi]   = data_in[gi*DATA_W +: DATA_W] ^ preload_word(widx[gi]);

      ram_read_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (READ_LATENCY)
      ) u_read_pipe (
        .clock      (clock),
        .sync_reset (sync_reset),
        .din        (raw_rd[gi]),
        .dout       (data_out[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  // Ascending port order: the highest-numbered writer lands last and wins.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (wr_en[k]) mem[widx[k]] <= wr_word[k];
    end
  end

  always_comb begin
    conflict_next = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int j = i + 1; j < NUM_PORTS; j++) begin
        if (wr_en[i] && wr_en[j] && (widx[i] == widx[j])) conflict_next = 1'b1;
      end
    end
  end

  always_comb begin
    oob_hits = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (w_rq[k] && !in_range[k]) oob_hits = oob_hits + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (sync_reset) begin
      wr_conflict_reg <= 1'b0;
      oob_count_reg   <= '0;
    end else begin
      wr_conflict_reg <= conflict_next;
      oob_count_reg   <= sat_add16(oob_count_reg, oob_hits);
    end
  end

  assign wr_conflict = wr_conflict_reg;
  assign oob_count   = oob_count_reg;

endmodule
